// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Pipeline <-> hazard controller signal bundle (ID/EX hazard inputs,
//            pipeline-register control outputs).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
  logic [4:0] id_rn;
  logic [4:0] id_rm;
  logic       id_use_rn;
  logic       id_use_rm;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       br_taken;
  logic       mem_busy;
  logic       pc_we;
  logic       ifid_we;
  logic       idex_bubble;
  logic       ifid_flush;
  logic       freeze;

  // master = pipeline datapath, slave = hazard controller
  modport master (
    output id_rn, id_rm, id_use_rn, id_use_rm, ex_rd, ex_is_load, br_taken, mem_busy,
    input  pc_we, ifid_we, idex_bubble, ifid_flush, freeze
  );

  modport slave (
    input  id_rn, id_rm, id_use_rn, id_use_rm, ex_rd, ex_is_load, br_taken, mem_busy,
    output pc_we, ifid_we, idex_bubble, ifid_flush, freeze
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Load-use stall, branch flush and memory-freeze control for a
//            5-stage pipeline. Optional stall counter: define HAZARD_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl (
  input  wire logic         clk,
  input  wire logic         reset,
  hazard_ctrl_if.slave      hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LU   = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [4:0] c_xzr = 5'd31;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_pend_br;
  logic   w_pend_br_nxt;
  logic   w_hit;
  logic   w_pc_we;
  logic   w_ifid_we;
  logic   w_idex_bubble;
  logic   w_ifid_flush;
  logic   w_freeze;

  // The LU cycle follows an inserted bubble, so the dependency is already resolved.
  assign w_hit = hz.ex_is_load && (hz.ex_rd != c_xzr) && (r_state != LU) &&
                 ((hz.id_use_rn && (hz.id_rn == hz.ex_rd)) ||
                  (hz.id_use_rm && (hz.id_rm == hz.ex_rd)));

  always_comb begin
    w_state_nxt   = RUN;
    w_pend_br_nxt = r_pend_br;
    w_pc_we       = 1'b1;
    w_ifid_we     = 1'b1;
    w_idex_bubble = 1'b0;
    w_ifid_flush  = 1'b0;
    w_freeze      = 1'b0;
    if (hz.mem_busy) begin
      w_state_nxt   = WAIT;
      w_pend_br_nxt = r_pend_br | hz.br_taken;
      w_pc_we       = 1'b0;
      w_ifid_we     = 1'b0;
      w_freeze      = 1'b1;
    end else if (hz.br_taken || r_pend_br) begin
      w_state_nxt   = RUN;
      w_pend_br_nxt = 1'b0;
      w_idex_bubble = 1'b1;
      w_ifid_flush  = 1'b1;
    end else if (w_hit) begin
      w_state_nxt   = LU;
      w_pc_we       = 1'b0;
      w_ifid_we     = 1'b0;
      w_idex_bubble = 1'b1;
    end
  end

  // Outputs are forced quiet for as long as reset is held, independent of the clock.
  always_comb begin
    hz.pc_we       = reset & w_pc_we;
    hz.ifid_we     = reset & w_ifid_we;
    hz.idex_bubble = reset & w_idex_bubble;
    hz.ifid_flush  = reset & w_ifid_flush;
    hz.freeze      = reset & w_freeze;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_pend_br <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_br <= w_pend_br_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 16'd0;
    end else if (!w_pc_we && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed scoreboard bench for hazard_ctrl control outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  // Output vector order: {pc_we, ifid_we, idex_bubble, ifid_flush, freeze}
  localparam logic [4:0] c_norm  = 5'b11000;
  localparam logic [4:0] c_stall = 5'b00100;
  localparam logic [4:0] c_br    = 5'b11110;
  localparam logic [4:0] c_frz   = 5'b00001;
  localparam logic [4:0] c_zero  = 5'b00000;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  hazard_ctrl_if hif ();

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt;
`endif

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] sb_exp[$];
  string      sb_tag[$];

  task automatic drive(input logic [4:0] rn, input logic [4:0] rm, input logic urn,
                       input logic urm, input logic [4:0] rd, input logic ld,
                       input logic br, input logic mb);
    hif.id_rn      = rn;
    hif.id_rm      = rm;
    hif.id_use_rn  = urn;
    hif.id_use_rm  = urm;
    hif.ex_rd      = rd;
    hif.ex_is_load = ld;
    hif.br_taken   = br;
    hif.mem_busy   = mb;
  endtask

  task automatic push(input logic [4:0] e, input string tag);
    sb_exp.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic compare();
    logic [4:0] obs;
    logic [4:0] e;
    string      t;
    obs = {hif.pc_we, hif.ifid_we, hif.idex_bubble, hif.ifid_flush, hif.freeze};
    e   = sb_exp.pop_front();
    t   = sb_tag.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
  endtask

  // One cycle: drive just after the edge, sample mid-cycle, advance to next edge+1.
  task automatic step(input logic [4:0] rn, input logic [4:0] rm, input logic urn,
                      input logic urm, input logic [4:0] rd, input logic ld,
                      input logic br, input logic mb, input logic [4:0] e,
                      input string tag);
    drive(rn, rm, urn, urm, rd, ld, br, mb);
    push(e, tag);
    #4;
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    push(c_zero, "reset_outputs");
    #3;
    compare();
    @(posedge clk);
    #1;
    reset = 1'b1;

    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, c_norm,  "no_event");
    // load-use on rn, then LU masks the same hit, then RUN detects again
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, c_stall, "lu_rn_hit");
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, c_norm,  "lu_state_masks");
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, c_stall, "lu_back_to_run");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_norm,  "lu_release");
    step(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, c_stall, "lu_rm_hit");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_norm,  "lu_rm_release");
    step(5'd9, 5'd4, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, c_norm,  "no_use_no_hit");
    step(5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, c_norm, "xzr_no_hit");
    step(5'd6, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, c_norm,  "not_load_no_hit");

    // mem_busy 3 cycles, branch in 2nd, flush on release
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, c_frz,   "busy1");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, c_frz,   "busy2_br");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, c_frz,   "busy3");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_br,    "pend_flush");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_norm,  "pend_cleared");

    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, c_frz,   "busy_then_br");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, c_br,    "release_with_br");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_norm,  "after_release_br");

    // branch beats load-use; no LU entered so the hit is seen next cycle
    step(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, c_br,    "br_over_hit");
    step(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, c_stall, "no_lu_after_br");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_norm,  "lu_after_hit");

    step(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, c_frz,   "busy_over_hit");
    step(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, c_stall, "wait_hit");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_norm,  "wait_hit_release");

    // reset mid-WAIT with a pending branch
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, c_frz,   "wait_pend");
    reset = 1'b0;
    push(c_zero, "rst_wait_out");
    #1;
    compare();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c_norm,  "rst_no_flush");

    // reset mid-LU: first cycle after release is RUN, so a hit stalls
    step(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, c_stall, "pre_rst_hit");
    reset = 1'b0;
    push(c_zero, "rst_lu_out");
    #1;
    compare();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, c_stall, "rst_lu_run");

`ifdef HAZARD_STATS_EN
    reset = 1'b0;
    #1;
    checks++;
    assert (stall_cnt === 16'h0000) else begin
      errors++;
      $error("FAIL cnt_reset observed=%h expected=%h", stall_cnt, 16'h0000);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    assert (stall_cnt === 16'hFFFE) else begin
      errors++;
      $error("FAIL cnt_fffe observed=%h expected=%h", stall_cnt, 16'hFFFE);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (stall_cnt === 16'hFFFF) else begin
      errors++;
      $error("FAIL cnt_sat observed=%h expected=%h", stall_cnt, 16'hFFFF);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert (stall_cnt === 16'hFFFF) else begin
      errors++;
      $error("FAIL cnt_hold observed=%h expected=%h", stall_cnt, 16'hFFFF);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first:
  clk  in  1  sole clock, all state updates on rising edge
  reset  in  1  asynchronous, active-low; 0 = in reset
  id_rn  in  5  ID-stage first source register number
  id_rm  in  5  ID-stage second source register number
  id_use_rn  in  1  ID instruction reads id_rn
  id_use_rm  in  1  ID instruction reads id_rm
  ex_rd  in  5  EX-stage destination register number
  ex_is_load  in  1  EX instruction is LDUR (result available only after MEM)
  br_taken  in  1  branch resolved taken in EX this cycle
  mem_busy  in  1  data memory not ready; pipeline must freeze
  pc_we  out  1  PC register write enable
  ifid_we  out  1  IF/ID register write enable
  idex_bubble  out  1  load NOP control word into ID/EX
  ifid_flush  out  1  clear IF/ID to NOP
  freeze  out  1  all pipeline registers (ID/EX, EX/MEM, MEM/WB) hold
  stall_cnt  out  16  stall-cycle count (present only with HAZARD_STATS_EN)

Function
REQ-002 SHALL implement FSM with states RUN, LU, WAIT and one pending-flush flag pend_br.
REQ-003 SHALL define load-use hit = ex_is_load AND ((id_use_rn AND id_rn==ex_rd) OR (id_use_rm AND id_rm==ex_rd)) AND ex_rd!=31; X31 (XZR) never produces a hit.
REQ-004 SHALL evaluate events each cycle in priority order: mem_busy > (br_taken OR pend_br) > load-use hit > none.
REQ-005 mem_busy=1 in any state SHALL drive freeze=1, pc_we=0, ifid_we=0, idex_bubble=0, ifid_flush=0 in the same cycle; next state WAIT.
REQ-006 br_taken=1 while mem_busy=1 SHALL set pend_br; pend_br holds until consumed.
REQ-007 In WAIT with mem_busy=0 SHALL behave as RUN for that cycle (outputs combinational per REQ-004); next state per those rules.
REQ-008 Branch event (br_taken OR pend_br, mem_busy=0) SHALL drive pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, freeze=0, clear pend_br, suppress load-use hit; next RUN.
REQ-009 Load-use hit in RUN or WAIT (no higher event) SHALL drive pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0, freeze=0 for exactly that cycle; next LU.
REQ-010 LU SHALL last one cycle, mask load-use detection, drive normal outputs (pc_we=1, ifid_we=1, others 0) unless mem_busy or branch applies; next RUN.
REQ-011 No event SHALL yield pc_we=1, ifid_we=1, idex_bubble=0, ifid_flush=0, freeze=0.
REQ-012 Outputs SHALL be combinational from state, pend_br and inputs; zero-cycle latency from event to control.
REQ-013 Simultaneous mem_busy deassert and br_taken SHALL be treated as branch event per REQ-008.

Reset
REQ-014 reset=0 SHALL asynchronously force state RUN, pend_br=0, stall_cnt=0.
REQ-015 While reset=0 outputs SHALL be pc_we=0, ifid_we=0, idex_bubble=0, ifid_flush=0, freeze=0.
REQ-016 Reset asserted mid-WAIT or mid-LU SHALL discard pending state; first cycle after release is RUN with pend_br=0.

Configuration
REQ-017 Macro HAZARD_STATS_EN defined: stall_cnt SHALL increment by 1 every non-reset cycle with pc_we=0, saturate at 16'hFFFF, never wrap.
REQ-018 Macro HAZARD_STATS_EN undefined: stall_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-019 ex_is_load=1, ex_rd=5, id_rn=5, id_use_rn=1 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle state LU, pc_we=1.
REQ-020 Same as REQ-019 but ex_rd=id_rn=31 -> no stall, pc_we=1, idex_bubble=0.
REQ-021 mem_busy=1 for 3 cycles with br_taken=1 in 2nd -> freeze=1, pc_we=0 for 3 cycles; 4th cycle ifid_flush=1, idex_bubble=1, pc_we=1; pend_br=0 after.
REQ-022 br_taken=1 and load-use hit together -> ifid_flush=1, idex_bubble=1, pc_we=1; no LU state entered.
REQ-023 reset=0 asserted mid-WAIT with pend_br=1 -> outputs zero immediately; after release, no flush issued, state RUN.
REQ-024 With HAZARD_STATS_EN, preload stall_cnt to 16'hFFFE, cause 3 stall cycles -> stall_cnt=16'hFFFF, holds.
